parking_slot_manager: RTL and testbench



---
 rtl/parking_slot_manager_pkg.sv | 28 ++
 rtl/free_slot_finder.sv | 43 ++++
 rtl/parking_slot_manager.sv | 108 ++++++++++
 tb/tb_parking_slot_manager.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_slot_manager_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_defs : shared slot/FSM definitions for parking_slot_manager  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package parking_defs;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        GATE  = 2'd2
    } state_t;

    function automatic logic [3:0] popcount8(input logic [NUM_SLOTS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/free_slot_finder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | free_slot_finder : first free slot at or after `start`, modulo 8      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module free_slot_finder
    import parking_defs::*;
(
    input  logic [NUM_SLOTS-1:0] free_map,
    input  logic [SLOT_W-1:0]    start,
    output logic [SLOT_W-1:0]    slot,
    output logic                 found
);

    logic [NUM_SLOTS-1:0] rotated;
    logic [SLOT_W-1:0]    offset;
    logic [SLOT_W-1:0]    idx;

    // Rotate so bit 0 is `start`; a plain lowest-bit priority search then wraps.
    always_comb begin
        rotated = '0;
        idx     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx        = start + SLOT_W'(i);
            rotated[i] = free_map[idx];
        end
    end

    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = SLOT_W'(i);
            end
        end
    end

    assign slot = start + offset;

endmodule
`default_nettype wire

// File: rtl/parking_slot_manager.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_slot_manager : free-slot bitmap, allocation and gate timing  |
// | Optional: ROUND_ROBIN_ALLOC_EN (rotating search start). Revision 1.0 |
// +----------------------------------------------------------------------+
module parking_slot_manager #(
    parameter int NUM_SLOTS   = 8,
    parameter int GATE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 exit_req,
    input  logic [2:0]           exit_slot,
    output logic [NUM_SLOTS-1:0] parking_capacity,
    output logic [3:0]           free_count,
    output logic [2:0]           assigned_slot,
    output logic                 slot_valid,
    output logic                 gate_open,
    output logic                 reject,
    output logic                 exit_err
);
    import parking_defs::*;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_SLOTS-1:0] cap_next;
    logic [SLOT_W-1:0]    find_start, find_slot;
    logic                 find_found;
    logic                 do_alloc, exit_ok, exit_bad;

`ifdef ROUND_ROBIN_ALLOC_EN
    logic [SLOT_W-1:0] last_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_slot <= 3'd7;
        end else if (do_alloc) begin
            last_slot <= find_slot;
        end
    end

    assign find_start = last_slot + 1'b1;
`else
    assign find_start = '0;
`endif

    free_slot_finder u_finder (
        .free_map (parking_capacity),
        .start    (find_start),
        .slot     (find_slot),
        .found    (find_found)
    );

    always_comb begin
        state_next = state;
        do_alloc   = 1'b0;
        case (state)
            IDLE:    if (enable && (parking_capacity != '0)) state_next = ALLOC;
            ALLOC: begin
                do_alloc   = find_found;
                state_next = find_found ? GATE : IDLE;
            end
            GATE:    if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // An exit can never hit the slot being allocated: that slot is free,
        // so its exit is flagged as an error instead of touching the bitmap.
        exit_ok  = exit_req && !parking_capacity[exit_slot];
        exit_bad = exit_req &&  parking_capacity[exit_slot];

        cap_next = parking_capacity;
        if (do_alloc) cap_next[find_slot] = 1'b0;
        if (exit_ok)  cap_next[exit_slot] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            parking_capacity <= '1;
            free_count       <= 4'd8;
            assigned_slot    <= '0;
            slot_valid       <= 1'b0;
            gate_open        <= 1'b0;
            reject           <= 1'b0;
            exit_err         <= 1'b0;
        end else begin
            state            <= state_next;
            parking_capacity <= cap_next;
            free_count       <= popcount8(cap_next);
            slot_valid       <= do_alloc;
            reject           <= (state == IDLE) && enable && (parking_capacity == '0);
            exit_err         <= exit_bad;
            // Registered one cycle behind GATE so the barrier lags the grant.
            gate_open        <= (state == GATE);
            if (do_alloc) assigned_slot <= find_slot;
            if (state == ALLOC) begin
                cnt <= CNT_W'(GATE_CYCLES - 1);
            end else if ((state == GATE) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parking_slot_manager.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_parking_slot_manager : scoreboard bench with a slot-level model    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_parking_slot_manager;

    localparam int G       = 4;
    localparam int K_ALLOC = 0;
    localparam int K_REJ   = 1;
    localparam int K_ERR   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_slot = 3'd0;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic [2:0] assigned_slot;
    logic       slot_valid, gate_open, reject, exit_err;

    parking_slot_manager #(.NUM_SLOTS(8), .GATE_CYCLES(G)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .exit_req         (exit_req),
        .exit_slot        (exit_slot),
        .parking_capacity (parking_capacity),
        .free_count       (free_count),
        .assigned_slot    (assigned_slot),
        .slot_valid       (slot_valid),
        .gate_open        (gate_open),
        .reject           (reject),
        .exit_err         (exit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stamp;
        int kind;
        int slot;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] cap_q[$];
    int         gate_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;

    // Reference model: which slots are free, how long the entrance stays busy.
    logic [7:0] mfree = 8'hFF;
    int         busy = 0;
    bit         alloc_next = 1'b0;
    int         last = 7;
    int         edge_no = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] f, input int start);
        for (int k = 0; k < 8; k++) begin
            if (f[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mfree      = 8'hFF;
        busy       = 0;
        alloc_next = 1'b0;
        last       = 7;
        edge_no    = 0;
        ev_q.delete();
        cap_q.delete();
        gate_q.delete();
    endtask

    // Drive one clock's inputs and push what the following edge must produce.
    task automatic step(input bit en, input bit ex, input int es);
        logic [7:0] nf;
        int s, start;
        bit acc, rej, err;
        ev_t e;
        @(negedge clk);
        enable    = en;
        exit_req  = ex;
        exit_slot = 3'(es);
        nf  = mfree;
        s   = -1;
        rej = 1'b0;
        err = 1'b0;
        if (alloc_next) begin
            start = (last + 1) % 8;
`ifndef ROUND_ROBIN_ALLOC_EN
            start = 0;
`endif
            s = pick(mfree, start);
            if (s >= 0) begin
                nf[s] = 1'b0;
                last  = s;
                gate_q.push_back(G);
            end
            alloc_next = 1'b0;
        end
        if (ex) begin
            if (mfree[es]) err = 1'b1;
            else           nf[es] = 1'b1;
        end
        acc = (busy == 0) && en;
        if (busy > 0) busy--;
        if (acc) begin
            if (mfree == 8'h00) rej = 1'b1;
            else begin
                busy       = G + 1;
                alloc_next = 1'b1;
            end
        end
        mfree = nf;
        if (s >= 0) begin e.stamp = edge_no; e.kind = K_ALLOC; e.slot = s;  ev_q.push_back(e); end
        if (rej)    begin e.stamp = edge_no; e.kind = K_REJ;   e.slot = -1; ev_q.push_back(e); end
        if (err)    begin e.stamp = edge_no; e.kind = K_ERR;   e.slot = -1; ev_q.push_back(e); end
        cap_q.push_back(nf);
        edge_no++;
        chk_en = 1'b1;
    endtask

    task automatic admit();
        step(1, 0, 0);
        repeat (G + 1) step(0, 0, 0);
    endtask

    task automatic pulse_chk(input string nm, input int kind, input logic act, input int cur);
        bit exp;
        ev_t e;
        exp = (ev_q.size() != 0) && (ev_q[0].stamp == cur) && (ev_q[0].kind == kind);
        check(nm, int'(act), int'(exp));
        if (exp) begin
            e = ev_q.pop_front();
            if (kind == K_ALLOC && act) check("assigned_slot", int'(assigned_slot), e.slot);
        end
    endtask

    initial begin : monitor
        int run;
        int mon_edge;
        logic [7:0] ec;
        run = 0;
        mon_edge = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                run      = 0;
                mon_edge = 0;
            end else if (chk_en) begin
                if (cap_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cap_queue: empty at edge %0d", mon_edge);
                end else begin
                    ec = cap_q.pop_front();
                    check("parking_capacity", int'(parking_capacity), int'(ec));
                    check("free_count", int'(free_count), $countones(ec));
                end
                pulse_chk("slot_valid", K_ALLOC, slot_valid, mon_edge);
                pulse_chk("reject",     K_REJ,   reject,     mon_edge);
                pulse_chk("exit_err",   K_ERR,   exit_err,   mon_edge);
                if (gate_open) begin
                    run++;
                end else if (run > 0) begin
                    if (gate_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL gate_open: unexpected %0d-cycle pulse", run);
                    end else begin
                        check("gate_len", run, gate_q.pop_front());
                    end
                    run = 0;
                end
                mon_edge++;
            end
        end
    end

    initial begin : stimulus
        #1 rst_n = 1'b0;
        #1;
        check("rst_capacity", int'(parking_capacity), 8'hFF);
        check("rst_free_count", int'(free_count), 8);
        check("rst_assigned_slot", int'(assigned_slot), 0);
        check("rst_slot_valid", int'(slot_valid), 0);
        check("rst_gate_open", int'(gate_open), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_exit_err", int'(exit_err), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        admit();                                  // slot 0, FE, gate 4 cycles
        for (int i = 0; i < 6; i++) admit();      // slots 1..6 -> 8'h80
        step(0, 1, 0); step(0, 1, 4); step(0, 1, 5);  // -> 8'b10110001
        admit();
        for (int i = 0; i < 8 && mfree != 8'h00; i++) admit();
        step(1, 0, 0);                            // full: reject
        repeat (2) step(0, 0, 0);
        step(1, 1, 5);                            // full + exit + enable
        step(0, 0, 0);
        admit();                                  // retry grants slot 5
        step(0, 1, 3); step(0, 1, 3);             // second exit of slot 3 errs
        step(0, 0, 0);
        step(1, 0, 0);                            // exit lands on the ALLOC edge
        step(0, 1, 6);
        repeat (G + 1) step(0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
        end
        repeat (G + 3) step(0, 0, 0);
        @(posedge clk);
        #2;
        check("events_left", ev_q.size(), 0);
        check("gates_left", gate_q.size(), 0);

        // Asynchronous reset in the middle of a gate sequence.
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge clk) chk_en = 1'b0;
        @(posedge clk);
        #3;
        check("gate_before_reset", int'(gate_open), 1);
        rst_n = 1'b0;
        #1;
        check("arst_gate_open", int'(gate_open), 0);
        check("arst_capacity", int'(parking_capacity), 8'hFF);
        check("arst_free_count", int'(free_count), 8);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        admit();
        repeat (2) step(0, 0, 0);
        @(posedge clk);
        #2;
        check("events_left_end", ev_q.size(), 0);
        check("gates_left_end", gate_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
